// File: rtl/seq_mult_param_if.sv
// seq_mult_param_if: start/busy/done handshake bundle for the sequential multiplier
//   start, signed_mode, a, b : request side (master drives, slave samples)
//   p, busy, done            : result side (slave drives, master observes)
interface seq_mult_param_if #(parameter int WIDTH = 8) ();
  logic start;
  logic signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2*WIDTH-1:0] p;
  logic busy;
  logic done;
  modport master (output start, signed_mode, a, b, input p, busy, done);
  modport slave (input start, signed_mode, a, b, output p, busy, done);
endinterface

// File: rtl/seq_mult_param.sv
// seq_mult_param: shift-add multiplier, one multiplier bit per clock, signed or unsigned per operation
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : seq_mult_param_if.slave (start/signed_mode/a/b in, p/busy/done out)
//   SEQ_MULT_EARLY_TERM_EN : when defined, RUN stops after the highest set multiplier bit
module seq_mult_param #(parameter int WIDTH = 8) (
  input logic clk,
  input logic reset,
  seq_mult_param_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] a_r;
  logic [2*WIDTH-1:0] b_r, p_r, term;
  logic sm_r, accept, last, sub;
  assign accept = bus.start && state != RUN;
  assign term = a_r[cnt] ? (b_r << cnt) : '0;
  // the top multiplier bit carries negative weight in two's complement
  assign sub = sm_r && cnt == CW'(WIDTH - 1);
`ifdef SEQ_MULT_EARLY_TERM_EN
  assign last = ((a_r >> cnt) >> 1) == '0;
`else
  assign last = cnt == CW'(WIDTH - 1);
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    if (state == RUN) state_nxt = last ? DONE : RUN;
    else state_nxt = accept ? RUN : IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      a_r <= '0;
      b_r <= '0;
      sm_r <= 1'b0;
      p_r <= '0;
    end else if (accept) begin
      cnt <= '0;
      a_r <= bus.a;
      b_r <= bus.signed_mode ? {{WIDTH{bus.b[WIDTH-1]}}, bus.b} : {{WIDTH{1'b0}}, bus.b};
      sm_r <= bus.signed_mode;
      p_r <= '0;
    end else if (state == RUN) begin
      cnt <= cnt + 1'b1;
      p_r <= sub ? p_r - term : p_r + term;
    end
  assign bus.p = p_r;
  assign bus.busy = state == RUN;
  assign bus.done = state == DONE;
endmodule

// File: tb/tb_seq_mult_param.sv
// tb_seq_mult_param: randomized and directed checks of seq_mult_param at WIDTH 8 and 16
module tb_seq_mult_param;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int pass = 0;
  int total = 0;
  always #5 clk = ~clk;
  seq_mult_param_if #(.WIDTH(8)) bus8 ();
  seq_mult_param_if #(.WIDTH(16)) bus16 ();
  seq_mult_param #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
  seq_mult_param #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16));

  // exact product of the operands interpreted per mode, reduced to 32 bits
  function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b, input logic sm, input int w);
    longint ea, eb;
    ea = longint'(a);
    eb = longint'(b);
    if (sm && a[w-1]) ea = ea - (longint'(1) << w);
    if (sm && b[w-1]) eb = eb - (longint'(1) << w);
    return 32'(ea * eb);
  endfunction

  function automatic int n_model(input logic [15:0] a, input int w);
    int n;
`ifdef SEQ_MULT_EARLY_TERM_EN
    n = 1;
    for (int i = 0; i < w; i++) if (a[i]) n = i + 1;
`else
    n = w;
`endif
    return n;
  endfunction

  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic sm);
    @(negedge clk);
    bus8.a = a;
    bus8.b = b;
    bus8.signed_mode = sm;
    bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
  endtask

  // waits for done; optionally pulses a competing start at RUN sample inj
  task automatic wait8(input int inj, input logic [7:0] ia, input logic [7:0] ib, output int lat, output int bc, output int ov);
    lat = 0;
    bc = 0;
    while (!bus8.done && lat < 100) begin
      bc += int'(bus8.busy);
      if (lat == inj) begin
        bus8.start = 1'b1;
        bus8.a = ia;
        bus8.b = ib;
      end
      @(negedge clk);
      bus8.start = 1'b0;
      lat++;
    end
    ov = int'(bus8.busy && bus8.done);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    total++; if (bus8.p !== 16'h0) $display("FAIL reset_p8 got %h exp 0", bus8.p); else pass++;
    total++; if (bus8.busy !== 1'b0) $display("FAIL reset_busy8 got %b exp 0", bus8.busy); else pass++;
    total++; if (bus8.done !== 1'b0) $display("FAIL reset_done8 got %b exp 0", bus8.done); else pass++;
    total++; if (bus16.p !== 32'h0) $display("FAIL reset_p16 got %h exp 0", bus16.p); else pass++;
    total++; if ({bus16.busy, bus16.done} !== 2'b00) $display("FAIL reset_bd16 got %b exp 00", {bus16.busy, bus16.done}); else pass++;
    reset = 1'b1;
  endtask

  task automatic test_unsigned;
    logic [7:0] a, b;
    logic [31:0] r;
    int lat, bc, ov;
    for (int i = 0; i < 8; i++) begin
      a = (i == 0) ? 8'd255 : 8'($urandom);
      b = (i == 0) ? 8'd255 : 8'($urandom);
      r = ref_prod({8'h0, a}, {8'h0, b}, 1'b0, 8);
      start8(a, b, 1'b0);
      wait8(-1, 8'h0, 8'h0, lat, bc, ov);
      total++; if (bus8.p !== r[15:0]) $display("FAIL unsigned_p %0d*%0d got %h exp %h", a, b, bus8.p, r[15:0]); else pass++;
      total++; if (lat !== n_model({8'h0, a}, 8)) $display("FAIL unsigned_lat a=%h got %0d exp %0d", a, lat, n_model({8'h0, a}, 8)); else pass++;
      total++; if (bc !== n_model({8'h0, a}, 8)) $display("FAIL unsigned_busy_len a=%h got %0d exp %0d", a, bc, n_model({8'h0, a}, 8)); else pass++;
      total++; if (ov !== 0) $display("FAIL unsigned_busy_done_overlap got %0d exp 0", ov); else pass++;
    end
    @(negedge clk);
    total++; if (bus8.p !== r[15:0]) $display("FAIL idle_hold_p got %h exp %h", bus8.p, r[15:0]); else pass++;
    total++; if ({bus8.busy, bus8.done} !== 2'b00) $display("FAIL idle_bd got %b exp 00", {bus8.busy, bus8.done}); else pass++;
  endtask

  task automatic test_signed;
    logic [7:0] ta [3] = '{8'h80, 8'hFD, 8'h07};
    logic [7:0] tb [3] = '{8'h80, 8'h05, 8'hFF};
    logic [7:0] a, b;
    logic [31:0] r;
    int lat, bc, ov;
    for (int i = 0; i < 10; i++) begin
      a = (i < 3) ? ta[i] : 8'($urandom);
      b = (i < 3) ? tb[i] : 8'($urandom);
      r = ref_prod({8'h0, a}, {8'h0, b}, 1'b1, 8);
      start8(a, b, 1'b1);
      wait8(-1, 8'h0, 8'h0, lat, bc, ov);
      total++; if (bus8.p !== r[15:0]) $display("FAIL signed_p %h*%h got %h exp %h", a, b, bus8.p, r[15:0]); else pass++;
      total++; if (lat !== n_model({8'h0, a}, 8)) $display("FAIL signed_lat a=%h got %0d exp %0d", a, lat, n_model({8'h0, a}, 8)); else pass++;
    end
  endtask

  task automatic test_early_term;
    logic [7:0] ta [3] = '{8'd3, 8'd0, 8'h80};
    logic [7:0] tb [3] = '{8'd11, 8'd77, 8'd1};
    logic sm [3] = '{1'b0, 1'b0, 1'b1};
    logic [31:0] r;
    int lat, bc, ov;
    for (int i = 0; i < 3; i++) begin
      r = ref_prod({8'h0, ta[i]}, {8'h0, tb[i]}, sm[i], 8);
      start8(ta[i], tb[i], sm[i]);
      wait8(-1, 8'h0, 8'h0, lat, bc, ov);
      total++; if (bus8.p !== r[15:0]) $display("FAIL early_p a=%h got %h exp %h", ta[i], bus8.p, r[15:0]); else pass++;
      total++; if (lat !== n_model({8'h0, ta[i]}, 8)) $display("FAIL early_lat a=%h got %0d exp %0d", ta[i], lat, n_model({8'h0, ta[i]}, 8)); else pass++;
    end
  endtask

  task automatic test_ignore_busy;
    int lat, bc, ov;
    start8(8'd2, 8'd3, 1'b0);
    wait8(1, 8'd9, 8'd9, lat, bc, ov);
    total++; if (bus8.p !== 16'd6) $display("FAIL ignore_p got %0d exp 6", bus8.p); else pass++;
    total++; if (lat !== n_model(16'd2, 8)) $display("FAIL ignore_lat got %0d exp %0d", lat, n_model(16'd2, 8)); else pass++;
    @(negedge clk);
    total++; if ({bus8.busy, bus8.done} !== 2'b00) $display("FAIL ignore_no_queue got %b exp 00", {bus8.busy, bus8.done}); else pass++;
  endtask

  task automatic test_back_to_back;
    int lat, bc, ov;
    start8(8'd2, 8'd3, 1'b0);
    wait8(-1, 8'h0, 8'h0, lat, bc, ov);
    total++; if (bus8.p !== 16'd6) $display("FAIL b2b_first_p got %0d exp 6", bus8.p); else pass++;
    bus8.a = 8'd4;
    bus8.b = 8'd5;
    bus8.signed_mode = 1'b0;
    bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    total++; if (bus8.busy !== 1'b1) $display("FAIL b2b_no_idle busy got %b exp 1", bus8.busy); else pass++;
    wait8(-1, 8'h0, 8'h0, lat, bc, ov);
    total++; if (bus8.p !== 16'd20) $display("FAIL b2b_second_p got %0d exp 20", bus8.p); else pass++;
    total++; if (lat !== n_model(16'd4, 8)) $display("FAIL b2b_second_lat got %0d exp %0d", lat, n_model(16'd4, 8)); else pass++;
  endtask

  task automatic test_reset_mid;
    int lat, bc, ov;
    int seen = 0;
    start8(8'd100, 8'd100, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (bus8.p !== 16'h0) $display("FAIL abort_p got %h exp 0", bus8.p); else pass++;
    total++; if ({bus8.busy, bus8.done} !== 2'b00) $display("FAIL abort_bd got %b exp 00", {bus8.busy, bus8.done}); else pass++;
    repeat (3) begin
      @(negedge clk);
      seen += int'(bus8.done);
    end
    reset = 1'b1;
    repeat (10) begin
      @(negedge clk);
      seen += int'(bus8.done);
    end
    total++; if (seen !== 0) $display("FAIL abort_no_done got %0d pulses exp 0", seen); else pass++;
    start8(8'd100, 8'd100, 1'b0);
    wait8(-1, 8'h0, 8'h0, lat, bc, ov);
    total++; if (bus8.p !== 16'h2710) $display("FAIL after_abort_p got %h exp 2710", bus8.p); else pass++;
  endtask

  task automatic test_sweep16;
    logic [15:0] a, b;
    logic sm;
    logic [31:0] r;
    int lat;
    for (int i = 0; i < 24; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      sm = i[0];
      r = ref_prod(a, b, sm, 16);
      @(negedge clk);
      bus16.a = a;
      bus16.b = b;
      bus16.signed_mode = sm;
      bus16.start = 1'b1;
      @(negedge clk);
      bus16.start = 1'b0;
      lat = 0;
      while (!bus16.done && lat < 100) begin
        @(negedge clk);
        lat++;
      end
      total++; if (bus16.p !== r) $display("FAIL w16_p sm=%b %h*%h got %h exp %h", sm, a, b, bus16.p, r); else pass++;
      total++; if (lat !== n_model(a, 16)) $display("FAIL w16_lat a=%h got %0d exp %0d", a, lat, n_model(a, 16)); else pass++;
    end
  endtask

  initial begin
    bus8.start = 1'b0;
    bus8.signed_mode = 1'b0;
    bus8.a = '0;
    bus8.b = '0;
    bus16.start = 1'b0;
    bus16.signed_mode = 1'b0;
    bus16.a = '0;
    bus16.b = '0;
    test_reset;
    test_unsigned;
    test_signed;
    test_early_term;
    test_ignore_busy;
    test_back_to_back;
    test_reset_mid;
    test_sweep16;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
